hamming_secded_dec: RTL and testbench
=====================================

Name: hamming_secded_dec

Overview:
Two-stage pipelined SEC-DED Hamming decoder. It sits directly downstream of err_inj and consumes one (possibly corrupted) encoded word per port; one instance is used per port (A, B). For each word it corrects single-bit errors, flags double-bit errors and keeps saturating error-event counters for the bench and status logic. A valid/ready handshake runs on both sides.

Parameters:
DW, 11, data bits per word
PW, derived localparam, Hamming parity bits: smallest PW with 2**PW >= DW+PW+1 (4 for DW=11)
CW, derived localparam, DW+PW+1 = encoded width (16 for DW=11; matches err_inj DATA_A default)
CNT_W, 16, error counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input word valid
o_ready  out  1  decoder accepts input this cycle
i_code  in  CW  encoded word (from err_inj o_err_out_x)
o_valid  out  1  decoded word valid
i_ready  in  1  downstream accepts output
o_data  out  DW  corrected data
o_sbit_err  out  1  single-bit error detected and corrected
o_dbit_err  out  1  double-bit error detected, uncorrectable
o_err_pos  out  PW  corrected bit position (0 = overall parity bit); 0 when no single error
i_cnt_clr  in  1  synchronous clear of both counters
o_sbit_cnt  out  CNT_W  accepted single-error words, saturating
o_dbit_cnt  out  CNT_W  accepted double-error words, saturating

Behaviour:
- Codeword layout: bit 0 = overall parity (XOR of bits 1..CW-1). Bits at power-of-two positions 1,2,4,8,… are Hamming parity bits. Remaining positions hold data bits, LSB first, in ascending position order. Even parity throughout.
- Reset (async assert, sync release): both stage valids 0, o_valid=0, o_data=0, o_sbit_err=0, o_dbit_err=0, o_err_pos=0, both counters 0.
- Pipeline advance: adv2 = !o_valid || i_ready. adv1 = !s1_valid || adv2. o_ready = adv1 (combinational).
- Stage 1 (on i_valid && o_ready): register the code word. Compute syndrome s[PW-1:0], where bit k = XOR of all positions with bit k set. Compute p = XOR of all CW bits. Register s, p and the word.
- Stage 2 (on s1_valid && adv2) classifies the word:
  - s==0 and p==0: no error.
  - p==1 and s<CW: single error at position s. Flip that bit, o_sbit_err=1, o_err_pos=s. s==0 means the overall parity bit itself is in error; data is unchanged.
  - p==1 and s>=CW: treated as uncorrectable, o_dbit_err=1. This case only arises for non-full codes.
  - p==0 and s!=0: double error. o_dbit_err=1, data extracted uncorrected, o_err_pos=0.
- o_sbit_err and o_dbit_err are never both 1.
- Latency: 2 cycles from input acceptance to o_valid with no backpressure. Throughput is 1 word per cycle.
- Backpressure: while o_valid && !i_ready, all outputs hold stable. Stage 1 holds if it is full. o_ready drops only when both stages are full and i_ready=0.
- Counters increment only on output acceptance (o_valid && i_ready), so a stalled word is counted once. They saturate at 2**CNT_W-1.
- i_cnt_clr has priority over an increment in the same cycle: result is 0.
- Output flags and data are registered. No combinational path from i_code to outputs.

Decomposition:
- Package hamming_pkg holds:
  - function calc_pw(dw)
  - function is_pow2(pos)
  - function hamming_enc(data), for bench and future encoder
  - function syndrome(code)
  - typedef enum err_e {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}
- One combinational sub-module hamming_syndrome (code -> s, p), reused by a future encoder-check block.
- Stage-2 correction and data extraction stay in hamming_secded_dec.

Test Plan:
1. Reset mid-stream: assert i_rst with both stages full. All outputs and counters go to 0 immediately. After release, the first word appears 2 cycles after acceptance.
2. Clean word: data 11'h5A5 -> hamming_enc, i_valid=1, i_ready=1 -> after 2 cycles o_data=11'h5A5, both flags 0, o_err_pos=0, counters unchanged.
3. Single error: encoded 11'h5A5 with bit 5 flipped -> o_data=11'h5A5, o_sbit_err=1, o_err_pos=5, o_sbit_cnt=1. With bit 0 flipped -> o_err_pos=0, data intact.
4. Double error: bits 3 and 9 flipped -> o_dbit_err=1, o_sbit_err=0, o_dbit_cnt increments by 1. Random sweep of 0/1/2-bit masks is checked against a package-function model.
5. Backpressure: 4 back-to-back words with single errors, i_ready=0 for 3 cycles -> o_ready low once both stages are full, no word lost or duplicated, o_sbit_cnt=4 exactly.
6. Counters: force o_sbit_cnt to 16'hFFFF and send another single-error word -> counter stays 16'hFFFF. Assert i_cnt_clr in the same cycle as an accepted error word -> counter is 0.

Source files
------------

// File: rtl/hamming_secded_dec_pkg.sv
// Shared SEC-DED Hamming definitions. The codeword layout is as follows:
// - bit 0 holds the overall parity.
// - The power-of-two positions hold the Hamming parity bits.
// - The data bits fill the remaining positions in ascending order.
// The fixed-width helpers below target the default 11-bit data configuration.
package hamming_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_e;

  // Smallest number of Hamming parity bits covering dw data bits plus overall parity
  function automatic int calc_pw(input int dw);
    int pw;
    pw = 1;
    while ((1 << pw) < dw + pw + 1) pw++;
    return pw;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  localparam int DW_DEF = 11;
  localparam int PW_DEF = calc_pw(DW_DEF);
  localparam int CW_DEF = DW_DEF + PW_DEF + 1;

  // Even-parity encoder for the default configuration
  function automatic logic [CW_DEF-1:0] hamming_enc(input logic [DW_DEF-1:0] data);
    logic [CW_DEF-1:0] c;
    logic              p;
    int                j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < CW_DEF; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos] = data[j];
        j++;
      end
    end
    for (int k = 0; k < PW_DEF; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CW_DEF; pos++) begin
        if ((((pos >> k) & 1) == 1) && !is_pow2(pos)) p = p ^ c[pos];
      end
      c[1 << k] = p;
    end
    c[0] = ^c[CW_DEF-1:1];
    return c;
  endfunction

  // Syndrome = XOR of the positions of all set bits
  function automatic logic [PW_DEF-1:0] syndrome(input logic [CW_DEF-1:0] code);
    logic [PW_DEF-1:0] s;
    s = '0;
    for (int pos = 1; pos < CW_DEF; pos++) begin
      if (code[pos]) s = s ^ PW_DEF'(pos);
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Handshake, data, status and counter signals of one decoder port.
interface hamming_secded_dec_if #(
  parameter int DW    = 11,
  parameter int CNT_W = 16
);
  localparam int PW = hamming_pkg::calc_pw(DW);
  localparam int CW = DW + PW + 1;

  logic             i_valid;
  logic             o_ready;
  logic [CW-1:0]    i_code;
  logic             o_valid;
  logic             i_ready;
  logic [DW-1:0]    o_data;
  logic             o_sbit_err;
  logic             o_dbit_err;
  logic [PW-1:0]    o_err_pos;
  logic             i_cnt_clr;
  logic [CNT_W-1:0] o_sbit_cnt;
  logic [CNT_W-1:0] o_dbit_cnt;

  // Decoder side
  modport slave (
    input  i_valid, i_code, i_ready, i_cnt_clr,
    output o_ready, o_valid, o_data, o_sbit_err, o_dbit_err, o_err_pos,
           o_sbit_cnt, o_dbit_cnt
  );

  // Producer / consumer side
  modport master (
    output i_valid, i_code, i_ready, i_cnt_clr,
    input  o_ready, o_valid, o_data, o_sbit_err, o_dbit_err, o_err_pos,
           o_sbit_cnt, o_dbit_cnt
  );
endinterface

// File: rtl/hamming_secded_dec_syndrome.sv
// Combinational syndrome and overall-parity generator for a SEC-DED codeword.
module hamming_syndrome #(
  parameter int CW = 16,
  parameter int PW = 4
) (
  input  logic [CW-1:0] code,
  output logic [PW-1:0] syn,
  output logic          par
);

  // Syndrome bit k covers every position with bit k set; par covers the whole word
  always_comb begin
    syn = '0;
    for (int pos = 1; pos < CW; pos++) begin
      if (code[pos]) syn = syn ^ PW'(pos);
    end
    par = ^code;
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined SEC-DED Hamming decoder with valid/ready on both sides.
// Stage 1 registers the word together with its syndrome and parity.
// Stage 2 does the following:
// - classifies the word,
// - corrects single-bit errors,
// - extracts the data bits,
// - keeps saturating per-class error counters.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int DW    = 11,
  parameter int CNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  hamming_secded_dec_if.slave bus
);

  localparam int PW = calc_pw(DW);
  localparam int CW = DW + PW + 1;

  function automatic logic [DW-1:0] extract_data(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int            j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        d[j] = c[pos];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             adv1;
  logic             adv2;
  logic [PW-1:0]    syn_p0;
  logic             par_p0;
  logic             vld_p1;
  logic [CW-1:0]    code_p1;
  logic [PW-1:0]    syn_p1;
  logic             par_p1;
  err_e             kind_p1;
  logic [CW-1:0]    fix_p1;
  logic             vld_p2;
  logic [DW-1:0]    data_p2;
  logic             sbit_p2;
  logic             dbit_p2;
  logic [PW-1:0]    pos_p2;
  logic [CNT_W-1:0] sbit_cnt;
  logic [CNT_W-1:0] dbit_cnt;

  hamming_syndrome #(.CW(CW), .PW(PW)) u_syn (
    .code (bus.i_code),
    .syn  (syn_p0),
    .par  (par_p0)
  );

  // A stage may load when it is empty or the stage after it is draining
  assign adv2        = !vld_p2 || bus.i_ready;
  assign adv1        = !vld_p1 || adv2;
  assign bus.o_ready = adv1;

  // ---- stage 0 -> 1: capture word, syndrome and overall parity ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      code_p1 <= '0;
      syn_p1  <= '0;
      par_p1  <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= bus.i_valid;
      if (bus.i_valid) begin
        code_p1 <= bus.i_code;
        syn_p1  <= syn_p0;
        par_p1  <= par_p0;
      end
    end
  end

  // Classify the staged word. Parity odd with a syndrome beyond the word is
  // only reachable in shortened codes and is reported as uncorrectable.
  always_comb begin
    kind_p1 = ERR_NONE;
    fix_p1  = code_p1;
    if (par_p1) begin
      if (int'(syn_p1) < CW) begin
        kind_p1 = ERR_SINGLE;
        fix_p1  = code_p1 ^ (CW'(1) << syn_p1);
      end else begin
        kind_p1 = ERR_DOUBLE;
      end
    end else if (syn_p1 != '0) begin
      kind_p1 = ERR_DOUBLE;
    end
  end

  // ---- stage 1 -> 2: registered corrected data and status flags ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sbit_p2 <= 1'b0;
      dbit_p2 <= 1'b0;
      pos_p2  <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= extract_data(fix_p1);
        sbit_p2 <= (kind_p1 == ERR_SINGLE);
        dbit_p2 <= (kind_p1 == ERR_DOUBLE);
        pos_p2  <= (kind_p1 == ERR_SINGLE) ? syn_p1 : '0;
      end
    end
  end

  // Count each word once, at output acceptance; clear wins over increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (vld_p2 && bus.i_ready) begin
      if (sbit_p2) sbit_cnt <= sat_inc(sbit_cnt);
      if (dbit_p2) dbit_cnt <= sat_inc(dbit_cnt);
    end
  end

  assign bus.o_valid    = vld_p2;
  assign bus.o_data     = data_p2;
  assign bus.o_sbit_err = sbit_p2;
  assign bus.o_dbit_err = dbit_p2;
  assign bus.o_err_pos  = pos_p2;
  assign bus.o_sbit_cnt = sbit_cnt;
  assign bus.o_dbit_cnt = dbit_cnt;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed and random bench for hamming_secded_dec. A scoreboard queue
// receives the expected result when a word is accepted. The queue is popped
// when the decoder hands a word downstream. A second instance with a 3-bit
// counter shares the stimulus and exposes counter saturation.
module tb_hamming_secded_dec;
  import hamming_pkg::*;

  localparam int DW    = 11;
  localparam int CNT_W = 16;
  localparam int PW    = calc_pw(DW);
  localparam int CW    = DW + PW + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sbit;
    logic          dbit;
    logic [PW-1:0] pos;
  } exp_t;

  logic i_clk;
  logic i_rst;
  exp_t sb[$];
  int   errors;
  int   checks;

  hamming_secded_dec_if #(.DW(DW), .CNT_W(CNT_W)) dif ();
  hamming_secded_dec_if #(.DW(DW), .CNT_W(3))     sif ();

  assign sif.i_valid   = dif.i_valid;
  assign sif.i_code    = dif.i_code;
  assign sif.i_ready   = dif.i_ready;
  assign sif.i_cnt_clr = dif.i_cnt_clr;

  hamming_secded_dec #(.DW(DW), .CNT_W(CNT_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (dif)
  );

  hamming_secded_dec #(.DW(DW), .CNT_W(3)) dut_sat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (sif)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] tb_extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int            j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        d[j] = c[pos];
        j++;
      end
    end
    return d;
  endfunction

  // Expected decode of hamming_enc(d) ^ mask. The expectation is derived
  // from the injected mask rather than from the syndrome.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] mask);
    exp_t e;
    int   n;
    n      = $countones(mask);
    e.data = d;
    e.sbit = 1'b0;
    e.dbit = 1'b0;
    e.pos  = '0;
    if (n == 1) begin
      e.sbit = 1'b1;
      for (int pos = 0; pos < CW; pos++) if (mask[pos]) e.pos = PW'(pos);
    end else if (n == 2) begin
      e.dbit = 1'b1;
      e.data = tb_extract(hamming_enc(d) ^ mask);
    end
    return e;
  endfunction

  // Output monitor: the transfer happens at the next rising edge
  always @(negedge i_clk) begin
    exp_t e;
    #2;
    if (!i_rst && dif.o_valid && dif.i_ready) begin
      if (sb.size() == 0) begin
        chk("extra_word", 32'(dif.o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("o_data", 32'(dif.o_data), 32'(e.data));
        chk("o_sbit_err", 32'(dif.o_sbit_err), 32'(e.sbit));
        chk("o_dbit_err", 32'(dif.o_dbit_err), 32'(e.dbit));
        chk("o_err_pos", 32'(dif.o_err_pos), 32'(e.pos));
      end
    end
  end

  task automatic send(input logic [CW-1:0] code, input exp_t e);
    bit done;
    done = 1'b0;
    @(negedge i_clk);
    dif.i_valid = 1'b1;
    dif.i_code  = code;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (dif.o_ready) begin
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        dif.i_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge i_clk);
      end
    end
    if (!done) begin
      dif.i_valid = 1'b0;
      chk("accept_timeout", 32'(dif.o_ready), 32'd1);
    end
  endtask

  task automatic send_m(input logic [DW-1:0] d, input logic [CW-1:0] mask);
    send(hamming_enc(d) ^ mask, model(d, mask));
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge i_clk);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_cnt();
    @(negedge i_clk);
    dif.i_cnt_clr = 1'b1;
    @(posedge i_clk);
    #1;
    dif.i_cnt_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] mask;
    logic [DW-1:0] d;
    int            nsb;
    int            ndb;
    int            k;
    int            a;
    int            b;
    errors = 0;
    checks = 0;
    i_rst         = 1'b1;
    dif.i_valid   = 1'b0;
    dif.i_code    = '0;
    dif.i_ready   = 1'b1;
    dif.i_cnt_clr = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_o_valid", 32'(dif.o_valid), 32'd0);
    chk("rst_o_data", 32'(dif.o_data), 32'd0);
    chk("rst_sbit_cnt", 32'(dif.o_sbit_cnt), 32'd0);
    i_rst = 1'b0;

    // Clean word
    send_m(11'h5A5, '0);
    drain();
    chk("clean_sbit_cnt", 32'(dif.o_sbit_cnt), 32'd0);
    chk("clean_dbit_cnt", 32'(dif.o_dbit_cnt), 32'd0);

    // Single errors: a data position, then the overall parity bit
    send_m(11'h5A5, CW'(1) << 5);
    drain();
    chk("single5_cnt", 32'(dif.o_sbit_cnt), 32'd1);
    send_m(11'h5A5, CW'(1));
    drain();
    chk("single0_cnt", 32'(dif.o_sbit_cnt), 32'd2);

    // Double error
    send_m(11'h5A5, (CW'(1) << 3) | (CW'(1) << 9));
    drain();
    chk("double_dbit_cnt", 32'(dif.o_dbit_cnt), 32'd1);
    chk("double_sbit_cnt", 32'(dif.o_sbit_cnt), 32'd2);

    // Random sweep of 0/1/2-bit error masks
    nsb = 0;
    ndb = 0;
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom_range(0, (1 << DW) - 1));
      k = $urandom_range(0, 2);
      a = $urandom_range(0, CW - 1);
      b = (a + $urandom_range(1, CW - 1)) % CW;
      mask = '0;
      if (k >= 1) mask[a] = 1'b1;
      if (k == 2) mask[b] = 1'b1;
      if (k == 1) nsb++;
      if (k == 2) ndb++;
      send_m(d, mask);
    end
    drain();
    chk("sweep_sbit_cnt", 32'(dif.o_sbit_cnt), 32'(2 + nsb));
    chk("sweep_dbit_cnt", 32'(dif.o_dbit_cnt), 32'(1 + ndb));

    // Backpressure: fill both stages, hold for 3 cycles, then release
    clr_cnt();
    chk("clr_sbit_cnt", 32'(dif.o_sbit_cnt), 32'd0);
    @(negedge i_clk);
    dif.i_ready = 1'b0;
    send_m(11'h123, CW'(1) << 3);
    send_m(11'h456, CW'(1) << 7);
    @(negedge i_clk);
    dif.i_valid = 1'b1;
    dif.i_code  = hamming_enc(11'h7FF) ^ (CW'(1) << 12);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_o_ready", 32'(dif.o_ready), 32'd0);
      chk("bp_hold_data", 32'(dif.o_data), 32'h123);
      chk("bp_hold_valid", 32'(dif.o_valid), 32'd1);
      @(negedge i_clk);
    end
    dif.i_valid = 1'b0;
    dif.i_ready = 1'b1;
    send_m(11'h7FF, CW'(1) << 12);
    send_m(11'h001, CW'(1) << 15);
    drain();
    chk("bp_sbit_cnt", 32'(dif.o_sbit_cnt), 32'd4);

    // Clear in the same cycle as an accepted single-error word
    @(negedge i_clk);
    dif.i_ready = 1'b0;
    send_m(11'h2AA, CW'(1) << 6);
    @(negedge i_clk);
    for (int n = 0; n < 10 && !dif.o_valid; n++) @(negedge i_clk);
    chk("clr_wait_valid", 32'(dif.o_valid), 32'd1);
    dif.i_cnt_clr = 1'b1;
    dif.i_ready   = 1'b1;
    @(posedge i_clk);
    #1;
    dif.i_cnt_clr = 1'b0;
    chk("clr_priority", 32'(dif.o_sbit_cnt), 32'd0);

    // Saturation: ten single errors against a 3-bit counter
    drain();
    for (int i = 0; i < 10; i++) send_m(DW'(i * 97), CW'(1) << (i + 1));
    drain();
    chk("sat_main_cnt", 32'(dif.o_sbit_cnt), 32'd10);
    chk("sat_small_cnt", 32'(sif.o_sbit_cnt), 32'd7);
    chk("sat_small_dbit", 32'(sif.o_dbit_cnt), 32'd0);

    // Reset with both stages full, then first-word latency
    @(negedge i_clk);
    dif.i_ready = 1'b0;
    send_m(11'h3C3, CW'(1) << 2);
    send_m(11'h0F0, (CW'(1) << 4) | (CW'(1) << 11));
    chk("full_o_ready", 32'(dif.o_ready), 32'd0);
    chk("full_o_valid", 32'(dif.o_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    sb.delete();
    chk("mrst_o_valid", 32'(dif.o_valid), 32'd0);
    chk("mrst_o_data", 32'(dif.o_data), 32'd0);
    chk("mrst_sbit_err", 32'(dif.o_sbit_err), 32'd0);
    chk("mrst_dbit_err", 32'(dif.o_dbit_err), 32'd0);
    chk("mrst_err_pos", 32'(dif.o_err_pos), 32'd0);
    chk("mrst_sbit_cnt", 32'(dif.o_sbit_cnt), 32'd0);
    chk("mrst_dbit_cnt", 32'(dif.o_dbit_cnt), 32'd0);
    chk("mrst_o_ready", 32'(dif.o_ready), 32'd1);
    @(negedge i_clk);
    i_rst       = 1'b0;
    dif.i_ready = 1'b1;
    send_m(11'h5A5, '0);
    chk("lat_cycle1_valid", 32'(dif.o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    chk("lat_cycle2_valid", 32'(dif.o_valid), 32'd1);
    chk("lat_cycle2_data", 32'(dif.o_data), 32'h5A5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
